// File: rtl/psram_cmd_responder.sv
// Responder side of the PSRAM command interface: serves 1/2/4-byte read/write
// commands from an on-chip byte buffer after a programmable number of wait states.
module psram_cmd_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 8,
  parameter int ADDR_BITS   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          data_i,
  input  logic [2:0]           size,
  input  logic                 rd_wr,
  input  logic                 start,
  output logic [31:0]          data_o,
  output logic                 done,
  output logic                 busy,
  output logic                 err
);

  localparam int MEM_AW = $clog2(DEPTH_BYTES);
  localparam int IDX_W  = MEM_AW + 1;
  localparam int CNT_W  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [MEM_AW-1:0]  base_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [2:0]         n_q;
  logic [1:0]         k_q;
  logic               rd_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         mem [DEPTH_BYTES];

  logic               accept;
  logic               reject;
  logic               last_byte;
  logic [IDX_W-1:0]   sum;
  logic [MEM_AW-1:0]  idx;

  assign accept    = (state_q == S_IDLE) && start;
  assign reject    = (size > 3'd2) || (addr >= ADDR_BITS'(DEPTH_BYTES));
  assign last_byte = ({1'b0, k_q} == (n_q - 3'd1));

  // Buffer index of the byte in flight, wrapping past the top of the buffer.
  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sum = {1'b0, base_q} + IDX_W'(k_q);
    idx = MEM_AW'(sum);
    if (sum >= IDX_W'(DEPTH_BYTES)) idx = MEM_AW'(sum - IDX_W'(DEPTH_BYTES));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (reject)                state_d = S_DONE;
        else if (WAIT_STATES == 0) state_d = S_XFER;
        else                       state_d = S_WAIT;
      end
      S_WAIT: if (cnt_q == '0) state_d = S_XFER;
      S_XFER: if (last_byte)   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done   = (state_q == S_DONE);
    err    = done && err_q;
    busy   = (state_q != S_IDLE);
    data_o = rdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      n_q     <= 3'd1;
      k_q     <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          base_q  <= MEM_AW'(addr);
          wdata_q <= data_i;
          rd_q    <= rd_wr;
          err_q   <= reject;
          k_q     <= '0;
          cnt_q   <= (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
          case (size)
            3'd0:    n_q <= 3'd1;
            3'd1:    n_q <= 3'd2;
            default: n_q <= 3'd4;
          endcase
          if (!reject && rd_wr) rdata_q <= '0;
        end
        S_WAIT: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        S_XFER: begin
          k_q <= k_q + 2'd1;
          if (rd_q) rdata_q[{k_q, 3'b000} +: 8] <= mem[idx];
        end
        default: ;
      endcase
    end
  end

  // NOTE: the buffer has no reset; a byte already in flight on the reset edge still lands.
  always_ff @(posedge clk) begin
    if (state_q == S_XFER && !rd_q) mem[idx] <= wdata_q[{k_q, 3'b000} +: 8];
  end

endmodule

// File: tb/tb_psram_cmd_responder.sv
// Scoreboard bench for psram_cmd_responder: a byte-array model predicts data,
// err and done latency for each command; results are popped as done fires.
`timescale 1ns/1ps
module tb_psram_cmd_responder;

  localparam int W     = 8;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] addr;
  logic [31:0] data_i;
  logic [2:0]  size;
  logic        rd_wr;
  logic        start;
  logic [31:0] data_o;
  logic        done;
  logic        busy;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  logic [7:0]  mdl_mem [DEPTH];
  logic [31:0] mdl_dout = '0;

  psram_cmd_responder #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(W), .ADDR_BITS(24)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_i(data_i), .size(size), .rd_wr(rd_wr),
    .start(start), .data_o(data_o), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: applies the command to the byte array and queues the expected result.
  function automatic void push_expect(input logic [23:0] a, input logic [31:0] d,
                                      input logic [2:0] s, input logic rw, input int lat_off);
    exp_t e;
    int   n;
    logic legal;
    legal = (s <= 3'd2) && (int'(a) < DEPTH);
    n     = (s == 3'd0) ? 1 : (s == 3'd1) ? 2 : 4;
    e.err = !legal;
    e.lat = lat_off + (legal ? (W + n + 1) : 1);
    if (legal && rw) begin
      mdl_dout = '0;
      for (int k = 0; k < n; k++) mdl_dout[8*k +: 8] = mdl_mem[(int'(a) + k) % DEPTH];
    end else if (legal) begin
      for (int k = 0; k < n; k++) mdl_mem[(int'(a) + k) % DEPTH] = d[8*k +: 8];
    end
    e.data = mdl_dout;
    sb_q.push_back(e);
  endfunction

  // One command: accept, scramble inputs while busy, wait for done, compare against the scoreboard.
  task automatic run_cmd(input logic [23:0] a, input logic [31:0] d, input logic [2:0] s,
                         input logic rw, input string name);
    exp_t e;
    int   cyc;
    push_expect(a, d, s, rw, 0);
    addr = a; data_i = d; size = s; rd_wr = rw; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    addr   = 24'($urandom);
    data_i = $urandom;
    size   = 3'($urandom);
    rd_wr  = 1'($urandom);
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    e = sb_q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: no done after %0d cycles", name, cyc);
    end else begin
      checks++;
      if (cyc !== e.lat) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", name, cyc, e.lat);
      end
      checks++;
      if (err !== e.err) begin
        errors++;
        $display("FAIL %s err: got %b expected %b", name, err, e.err);
      end
      checks++;
      if (data_o !== e.data) begin
        errors++;
        $display("FAIL %s data_o: got %h expected %h", name, data_o, e.data);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b err=%b expected 0 0 0", name, done, busy, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; addr = '0; data_i = '0; size = '0; rd_wr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: done=%b err=%b busy=%b data_o=%h expected 0 0 0 00000000",
               done, err, busy, data_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    run_cmd(24'h10, 32'hDEADBEEF, 3'b010, 1'b0, "wr4_0x10");
    run_cmd(24'h10, 32'h0,        3'b010, 1'b1, "rd4_0x10");
  endtask

  task automatic test_partial_read();
    run_cmd(24'h11, 32'h0, 3'b000, 1'b1, "rd1_0x11");
    run_cmd(24'h12, 32'h0, 3'b001, 1'b1, "rd2_0x12");
  endtask

  task automatic test_wrap();
    run_cmd(24'h003, 32'h0,        3'b000, 1'b0, "wr1_0x003");
    run_cmd(24'h3FF, 32'h44332211, 3'b010, 1'b0, "wr4_wrap");
    run_cmd(24'h3FF, 32'h0,        3'b000, 1'b1, "rd1_0x3ff");
    run_cmd(24'h000, 32'h0,        3'b010, 1'b1, "rd4_0x000");
  endtask

  task automatic test_reject();
    run_cmd(24'h400,    32'h0,        3'b010, 1'b1, "rej_addr_rd");
    run_cmd(24'hFFFFFF, 32'hCAFEF00D, 3'b000, 1'b0, "rej_addr_wr");
    run_cmd(24'h10,     32'h12345678, 3'b011, 1'b0, "rej_size_wr");
    run_cmd(24'h10,     32'h0,        3'b111, 1'b1, "rej_size_rd");
    run_cmd(24'h10,     32'h0,        3'b010, 1'b1, "rd4_after_rej");
  endtask

  // start held high: one accept per IDLE cycle, done spaced W+N+2 apart.
  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    int   dones;
    int   idle_between;
    for (int i = 0; i < 3; i++) push_expect(24'h10, 32'h0, 3'b010, 1'b1, i * (W + 6));
    addr = 24'h10; data_i = '0; size = 3'b010; rd_wr = 1'b1; start = 1'b1;
    @(negedge clk);
    cyc = 1; dones = 0; idle_between = 0;
    while (dones < 3 && cyc < 200) begin
      if (done) begin
        e = sb_q.pop_front();
        checks++;
        if (cyc !== e.lat || data_o !== e.data || err !== e.err) begin
          errors++;
          $display("FAIL b2b_done%0d: cycle=%0d data_o=%h err=%b expected cycle=%0d data_o=%h err=%b",
                   dones, cyc, data_o, err, e.lat, e.data, e.err);
        end
        if (dones > 0) begin
          checks++;
          if (idle_between !== 1) begin
            errors++;
            $display("FAIL b2b_idle%0d: idle cycles=%0d expected 1", dones, idle_between);
          end
        end
        idle_between = 0;
        dones++;
        if (dones == 3) start = 1'b0;
      end else if (!busy) begin
        idle_between++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (dones !== 3) begin
      errors++;
      $display("FAIL b2b_count: done pulses=%0d expected 3", dones);
      sb_q.delete();
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_release: busy=%b expected 0", busy);
    end
  endtask

  // Reset lands on the edge that writes byte 1 of a 4-byte write.
  task automatic test_reset_abort();
    int seen;
    run_cmd(24'h20, 32'h04030201, 3'b010, 1'b0, "wr4_0x20_pre");
    addr = 24'h20; data_i = 32'hAABBCCDD; size = 3'b010; rd_wr = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || data_o !== 32'h0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b data_o=%h expected 0 0 00000000", busy, done, data_o);
    end
    mdl_mem[32'h20] = 8'hDD;
    mdl_mem[32'h21] = 8'hCC;
    mdl_dout = '0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: done pulses=%0d expected 0", seen);
    end
    run_cmd(24'h20, 32'h0, 3'b010, 1'b1, "rd4_after_abort");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_read();
    test_wrap();
    test_reject();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
